// File: rtl/wave_pkg.sv
// Shared definitions for the sawtooth generator / meter pair.
// Holds the default sample width, the default period-counter width with its
// saturation value, and the meter FSM state encoding.
package wave_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 24;

    localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        MEASURE = 2'd2
    } state_e;

endpackage

// File: rtl/wrap_detect.sv
// Wrap detector for a sawtooth sample stream.
// Keeps the previously accepted sample and flags a wrap whenever the current
// valid sample sits at least DROP_MIN below it.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           synchronous clear of the stored sample
//   accept          current sample is consumed by the meter (updates prev)
//   sample_valid    sample strobe
//   sample          incoming unsigned sample
//   wrap            combinational wrap flag for the current sample
module wrap_detect
    import wave_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DROP_MIN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic              wrap
);

    logic [DATA_W-1:0] prev_q;
    logic [DATA_W-1:0] prev_d;
    logic [DATA_W:0]   drop;

    always_comb begin
        prev_d = prev_q;
        if (clear) begin
            prev_d = '0;
        end else if (accept) begin
            prev_d = sample;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // One extra bit so the subtraction never wraps; the sample < prev term
    // keeps rising or flat steps from being seen as drops.
    assign drop = {1'b0, prev_q} - {1'b0, sample};
    assign wrap = sample_valid && (sample < prev_q) && (drop >= (DATA_W+1)'(DROP_MIN));

endmodule

// File: rtl/sawtooth_wave_meter.sv
// Sawtooth wave meter: measures period (in samples), peak and trough of each
// complete sawtooth cycle delimited by two wraps.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ena             measurement enable; low returns to IDLE and drops lock
//   clear           synchronous clear of results and state
//   sample_valid    sample strobe
//   sample          incoming unsigned sample
//   period          samples in last complete cycle
//   peak, trough    max / min sample in last complete cycle
//   meas_valid      one-cycle pulse when results update
//   locked          a full cycle has been measured without overflow
//   overflow        sticky period-counter saturation flag
module sawtooth_wave_meter
    import wave_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int DROP_MIN   = 2,
    parameter int MIN_PERIOD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clear,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic [CNT_W-1:0]  period,
    output logic [DATA_W-1:0] peak,
    output logic [DATA_W-1:0] trough,
    output logic              meas_valid,
    output logic              locked,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] CntSat = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MinCnt = CNT_W'(MIN_PERIOD);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] runMax_q, runMax_d;
    logic [DATA_W-1:0] runMin_q, runMin_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic [DATA_W-1:0] trough_q, trough_d;
    logic              measValid_q, measValid_d;
    logic              locked_q, locked_d;
    logic              overflow_q, overflow_d;
    logic              wrap;
    logic              accept;

    // A sample dropped by clear or arriving while disabled never reaches prev.
    assign accept = sample_valid && ena && !clear;

    wrap_detect #(
        .DATA_W   (DATA_W),
        .DROP_MIN (DROP_MIN)
    ) u_wrap_detect (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .accept       (accept),
        .sample_valid (sample_valid),
        .sample       (sample),
        .wrap         (wrap)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        runMax_d    = runMax_q;
        runMin_d    = runMin_q;
        period_d    = period_q;
        peak_d      = peak_q;
        trough_d    = trough_q;
        measValid_d = 1'b0;
        locked_d    = locked_q;
        overflow_d  = overflow_q;

        if (clear) begin
            state_d    = IDLE;
            count_d    = '0;
            runMax_d   = '0;
            runMin_d   = '0;
            period_d   = '0;
            peak_d     = '0;
            trough_d   = '0;
            locked_d   = 1'b0;
            overflow_d = 1'b0;
        end else if (!ena) begin
            state_d  = IDLE;
            locked_d = 1'b0;
        end else if (sample_valid) begin
            case (state_q)
                IDLE: begin
                    state_d = SYNC;
                end
                SYNC: begin
                    if (wrap) begin
                        state_d  = MEASURE;
                        count_d  = CNT_W'(1);
                        runMax_d = sample;
                        runMin_d = sample;
                    end
                end
                MEASURE: begin
                    // Wraps closer than MIN_PERIOD to the last one are glitches
                    // and fall through to the ordinary accumulate path.
                    if (wrap && (count_q >= MinCnt)) begin
                        period_d    = count_q;
                        peak_d      = runMax_q;
                        trough_d    = runMin_q;
                        measValid_d = 1'b1;
                        locked_d    = 1'b1;
                        count_d     = CNT_W'(1);
                        runMax_d    = sample;
                        runMin_d    = sample;
                    end else begin
                        count_d = count_q + 1'b1;
                        if (sample > runMax_q) begin
                            runMax_d = sample;
                        end
                        if (sample < runMin_q) begin
                            runMin_d = sample;
                        end
                        // Reaching the top of the counter abandons this cycle;
                        // published results are left untouched.
                        if (count_d == CntSat) begin
                            overflow_d = 1'b1;
                            locked_d   = 1'b0;
                            state_d    = SYNC;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            runMax_q    <= '0;
            runMin_q    <= '0;
            period_q    <= '0;
            peak_q      <= '0;
            trough_q    <= '0;
            measValid_q <= 1'b0;
            locked_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            runMax_q    <= runMax_d;
            runMin_q    <= runMin_d;
            period_q    <= period_d;
            peak_q      <= peak_d;
            trough_q    <= trough_d;
            measValid_q <= measValid_d;
            locked_q    <= locked_d;
            overflow_q  <= overflow_d;
        end
    end

    assign period     = period_q;
    assign peak       = peak_q;
    assign trough     = trough_q;
    assign meas_valid = measValid_q;
    assign locked     = locked_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_sawtooth_wave_meter.sv
// Testbench for sawtooth_wave_meter: a default-width instance for the ramp,
// glitch, enable and reset cases, and a CNT_W=4 instance for saturation.
module tb_sawtooth_wave_meter;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        clear;
    logic        sample_valid;
    logic [15:0] sample;

    logic [23:0] period;
    logic [15:0] peak;
    logic [15:0] trough;
    logic        meas_valid;
    logic        locked;
    logic        overflow;

    logic [3:0]  sPeriod;
    logic [15:0] sPeak;
    logic [15:0] sTrough;
    logic        sMeasValid;
    logic        sLocked;
    logic        sOverflow;

    int checks;
    int errors;
    int pulseCount;
    int sPulseCount;
    int lastPeriod;

    typedef struct {
        int top;
        int hold;
        int gap;
        int expPeriod;
        int expPeak;
        int expTrough;
    } rampVec_t;

    rampVec_t vecs[3];

    sawtooth_wave_meter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .clear        (clear),
        .sample_valid (sample_valid),
        .sample       (sample),
        .period       (period),
        .peak         (peak),
        .trough       (trough),
        .meas_valid   (meas_valid),
        .locked       (locked),
        .overflow     (overflow)
    );

    sawtooth_wave_meter #(.CNT_W(4)) dutSmall (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .clear        (clear),
        .sample_valid (sample_valid),
        .sample       (sample),
        .period       (sPeriod),
        .peak         (sPeak),
        .trough       (sTrough),
        .meas_valid   (sMeasValid),
        .locked       (sLocked),
        .overflow     (sOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance to the next falling edge, log any result pulse produced by the
    // previous input, then drive the new input.
    task automatic applyStimulus(input logic v, input int s);
        @(negedge clk);
        if (meas_valid) begin
            pulseCount++;
            lastPeriod = int'(period);
        end
        if (sMeasValid) begin
            sPulseCount++;
        end
        sample_valid = v;
        sample       = 16'(s);
    endtask

    task automatic sendSample(input int s, input int gap);
        applyStimulus(1'b1, s);
        for (int g = 0; g < gap; g++) begin
            applyStimulus(1'b0, s);
        end
    endtask

    task automatic sendRamp(input int first, input int top, input int hold, input int gap);
        for (int v = first; v <= top; v++) begin
            for (int h = 0; h < hold; h++) begin
                sendSample(v, gap);
            end
        end
    endtask

    task automatic doClear();
        @(negedge clk);
        clear        = 1'b1;
        sample_valid = 1'b0;
        @(negedge clk);
        clear       = 1'b0;
        pulseCount  = 0;
        sPulseCount = 0;
        lastPeriod  = 0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        pulseCount   = 0;
        sPulseCount  = 0;
        lastPeriod   = 0;
        rst_n        = 1'b0;
        ena          = 1'b1;
        clear        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;

        vecs[0] = '{top: 9, hold: 1, gap: 0, expPeriod: 10, expPeak: 9, expTrough: 0};
        vecs[1] = '{top: 9, hold: 4, gap: 0, expPeriod: 40, expPeak: 9, expTrough: 0};
        vecs[2] = '{top: 9, hold: 1, gap: 1, expPeriod: 10, expPeak: 9, expTrough: 0};

        #23;
        checkOutput("reset_period", int'(period), 0);
        checkOutput("reset_meas_valid", int'(meas_valid), 0);
        checkOutput("reset_locked", int'(locked), 0);
        checkOutput("reset_overflow", int'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three ramp cycles then a final wrap: the third-cycle wrap and the
        // final wrap each close a full cycle.
        for (int i = 0; i < 3; i++) begin
            doClear();
            for (int c = 0; c < 3; c++) begin
                sendRamp(0, vecs[i].top, vecs[i].hold, vecs[i].gap);
            end
            checkOutput($sformatf("ramp%0d_first_pulses", i), pulseCount, 1);
            checkOutput($sformatf("ramp%0d_first_period", i), lastPeriod, vecs[i].expPeriod);
            applyStimulus(1'b1, 0);
            @(negedge clk);
            checkOutput($sformatf("ramp%0d_meas_valid", i), int'(meas_valid), 1);
            checkOutput($sformatf("ramp%0d_period", i), int'(period), vecs[i].expPeriod);
            checkOutput($sformatf("ramp%0d_peak", i), int'(peak), vecs[i].expPeak);
            checkOutput($sformatf("ramp%0d_trough", i), int'(trough), vecs[i].expTrough);
            checkOutput($sformatf("ramp%0d_locked", i), int'(locked), 1);
            sample_valid = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("ramp%0d_pulse_width", i), int'(meas_valid), 0);
        end

        // Glitch drop 5->3 two samples after a wrap must be absorbed.
        doClear();
        sendRamp(0, 9, 1, 0);
        sendSample(0, 0);
        sendSample(5, 0);
        sendSample(3, 0);
        applyStimulus(1'b1, 4);
        checkOutput("glitch_no_pulse", pulseCount, 0);
        sendRamp(5, 9, 1, 0);
        applyStimulus(1'b1, 0);
        @(negedge clk);
        checkOutput("glitch_meas_valid", int'(meas_valid), 1);
        checkOutput("glitch_period", int'(period), 9);
        checkOutput("glitch_peak", int'(peak), 9);
        checkOutput("glitch_trough", int'(trough), 0);
        sample_valid = 1'b0;

        // Saturation on the 4-bit counter: lock at period 10, then a 9->7 wrap
        // followed by constant 7s; the 14th repeat takes the count to 15.
        doClear();
        sendRamp(0, 9, 1, 0);
        sendRamp(0, 9, 1, 0);
        sendRamp(0, 9, 1, 0);
        sendSample(7, 0);
        applyStimulus(1'b0, 7);
        checkOutput("ovf_pre_pulses", sPulseCount, 2);
        checkOutput("ovf_pre_locked", int'(sLocked), 1);
        checkOutput("ovf_pre_period", int'(sPeriod), 10);
        for (int n = 0; n < 13; n++) begin
            sendSample(7, 0);
        end
        applyStimulus(1'b0, 7);
        checkOutput("ovf_count14", int'(sOverflow), 0);
        for (int n = 0; n < 6; n++) begin
            sendSample(7, 0);
        end
        applyStimulus(1'b0, 7);
        checkOutput("ovf_flag", int'(sOverflow), 1);
        checkOutput("ovf_locked", int'(sLocked), 0);
        checkOutput("ovf_period_hold", int'(sPeriod), 10);
        checkOutput("ovf_peak_hold", int'(sPeak), 9);
        checkOutput("ovf_no_extra_pulse", sPulseCount, 2);
        doClear();
        checkOutput("clear_overflow", int'(sOverflow), 0);
        checkOutput("clear_period", int'(sPeriod), 0);
        checkOutput("clear_peak", int'(sPeak), 0);
        checkOutput("clear_main_period", int'(period), 0);

        // Enable dropped mid-cycle: lock lost, results held, wraps ignored;
        // after re-enable two wraps are needed before the next result.
        doClear();
        sendRamp(0, 9, 1, 0);
        sendRamp(0, 9, 1, 0);
        sendSample(0, 0);
        sendRamp(1, 4, 1, 0);
        checkOutput("ena_pre_locked", int'(locked), 1);
        ena = 1'b0;
        sendRamp(5, 9, 1, 0);
        sendRamp(0, 9, 1, 0);
        sendRamp(0, 2, 1, 0);
        applyStimulus(1'b0, 2);
        checkOutput("ena_low_locked", int'(locked), 0);
        checkOutput("ena_low_period", int'(period), 10);
        checkOutput("ena_low_pulses", pulseCount, 1);
        ena = 1'b1;
        sendRamp(3, 9, 1, 0);
        sendSample(0, 0);
        sendRamp(1, 9, 1, 0);
        checkOutput("reena_one_wrap", pulseCount, 1);
        sendSample(0, 0);
        applyStimulus(1'b0, 0);
        checkOutput("reena_two_wraps", pulseCount, 2);
        checkOutput("reena_period", lastPeriod, 10);
        checkOutput("reena_locked", int'(locked), 1);

        // Asynchronous reset between edges clears everything immediately.
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_period", int'(period), 0);
        checkOutput("async_rst_peak", int'(peak), 0);
        checkOutput("async_rst_locked", int'(locked), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_meas_valid", int'(meas_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
